// File: rtl/dtree_pkg.sv
// dtree_pkg: shared state encoding, default widths and class legality for the vote reader.
package dtree_pkg;
    localparam int DEF_FEAT_W      = 8;
    localparam int DEF_CLASS_W     = 4;
    localparam int DEF_NUM_CLASSES = 10;

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, SCAN, HOLD} state_t;

    function automatic logic class_legal(input int c, input int n);
        return c < n;
    endfunction
endpackage

// File: rtl/dtree_vote_hist.sv
// dtree_vote_hist: per-class 4-bit vote counters with increment, clear and indexed read.
module dtree_vote_hist
    import dtree_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int CLASS_W     = DEF_CLASS_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic [CLASS_W-1:0] inc_idx,
    input  logic               clr,
    input  logic [CLASS_W-1:0] rd_idx,
    output logic [3:0]         rd_cnt
);
    logic [3:0] hist [NUM_CLASSES];

    always_ff @(posedge clk or posedge rst) begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (rst || clr)
                hist[i] <= '0;
            else if (inc && inc_idx == CLASS_W'(i))
                hist[i] <= hist[i] + 4'd1;
        end
    end

    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < NUM_CLASSES; i++)
            if (rd_idx == CLASS_W'(i)) rd_cnt = hist[i];
    end
endmodule

// File: rtl/dtree_vote_reader.sv
// dtree_vote_reader: holds features on a combinational tree, samples its class and emits a majority vote.
module dtree_vote_reader
    import dtree_pkg::*;
#(
    parameter int FEAT_W        = DEF_FEAT_W,
    parameter int CLASS_W       = DEF_CLASS_W,
    parameter int NUM_CLASSES   = DEF_NUM_CLASSES,
    parameter int SETTLE_CYCLES = 3,
    parameter int VOTE_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FEAT_W-1:0]  in_feature,
    output logic [FEAT_W-1:0]  feat_out,
    input  logic [CLASS_W-1:0] tree_class,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic [3:0]         out_votes,
    output logic               out_err
);
    state_t             state, state_n;
    logic [3:0]         settle_cnt, sample_cnt, best_cnt, hist_cnt;
    logic [CLASS_W-1:0] scan_idx, best_idx;
    logic               err, legal, last, take;

    assign legal = class_legal(int'(tree_class), NUM_CLASSES);
    assign last  = scan_idx == CLASS_W'(NUM_CLASSES - 1);
    assign take  = hist_cnt > best_cnt;

    dtree_vote_hist #(.NUM_CLASSES(NUM_CLASSES), .CLASS_W(CLASS_W)) u_hist (
        .clk(clk),
        .rst(rst),
        .inc(state == SAMPLE && legal),
        .inc_idx(tree_class),
        .clr(state == SCAN && last),
        .rd_idx(scan_idx),
        .rd_cnt(hist_cnt)
    );

    always_comb begin
        state_n  = state;
        in_ready = state == IDLE;
        case (state)
            IDLE:    if (in_valid) state_n = SETTLE;
            SETTLE:  if (settle_cnt == 4'd0) state_n = SAMPLE;
            SAMPLE:  state_n = (sample_cnt + 4'd1 == 4'(VOTE_DEPTH)) ? SCAN : IDLE;
            SCAN:    if (last) state_n = HOLD;
            HOLD:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            feat_out   <= '0;
            settle_cnt <= '0;
            sample_cnt <= '0;
            err        <= 1'b0;
            scan_idx   <= '0;
            best_idx   <= '0;
            best_cnt   <= '0;
            out_valid  <= 1'b0;
            out_class  <= '0;
            out_votes  <= '0;
            out_err    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                feat_out   <= in_feature;
                settle_cnt <= 4'(SETTLE_CYCLES - 1);
            end
            if (state == SETTLE && settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
            if (state == SAMPLE) begin
                sample_cnt <= sample_cnt + 4'd1;
                if (!legal) err <= 1'b1;
                scan_idx <= '0;
                best_idx <= '0;
                best_cnt <= '0;
            end
            // strict '>' keeps the earliest (lowest) index on ties
            if (state == SCAN) begin
                scan_idx <= scan_idx + 1'b1;
                if (take) begin
                    best_idx <= scan_idx;
                    best_cnt <= hist_cnt;
                end
                if (last) begin
                    out_class  <= take ? scan_idx : best_idx;
                    out_votes  <= take ? hist_cnt : best_cnt;
                    out_err    <= err;
                    out_valid  <= 1'b1;
                    sample_cnt <= '0;
                    err        <= 1'b0;
                end
            end
            if (state == HOLD && out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dtree_vote_reader.sv
// tb_dtree_vote_reader: directed vote vectors with hand-computed majority results.
module tb_dtree_vote_reader;
    logic       clk = 0, rst = 1;
    logic       in_valid = 0, in_ready, out_valid, out_ready = 0, out_err;
    logic [7:0] in_feature = 0, feat_out;
    logic [3:0] tree_class = 0, out_class, out_votes;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    dtree_vote_reader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_feature(in_feature), .feat_out(feat_out), .tree_class(tree_class),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_votes(out_votes), .out_err(out_err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input int f, input int c);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 0, 1);
        in_valid   = 1;
        in_feature = 8'(f);
        tree_class = 4'(c);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic finish_vote(input int ec, input int ev, input int ee, input int hold);
        int lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", lat, 14);
        chk("out_class", int'(out_class), ec);
        chk("out_votes", int'(out_votes), ev);
        chk("out_err", int'(out_err), ee);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_class", int'(out_class), ec);
            chk("hold_votes", int'(out_votes), ev);
            chk("hold_err", int'(out_err), ee);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1;
        @(posedge clk);
        #1 chk("valid_drop", int'(out_valid), 0);
        chk("ready_after", int'(in_ready), 1);
        out_ready = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_feat", int'(feat_out), 0);
        chk("rst_class", int'(out_class), 0);
        chk("rst_votes", int'(out_votes), 0);
        chk("rst_err", int'(out_err), 0);
        @(negedge clk) rst = 0;

        send(8'h11, 3); send(8'h12, 3); send(8'h13, 7); send(8'h14, 3);
        finish_vote(3, 3, 0, 0);

        send(8'h21, 5); send(8'h22, 2); send(8'h23, 5); send(8'h24, 2);
        finish_vote(2, 2, 0, 0);

        send(8'h31, 12); send(8'h32, 4); send(8'h33, 4); send(8'h34, 15);
        finish_vote(4, 2, 1, 0);

        send(8'h41, 15); send(8'h42, 10); send(8'h43, 11); send(8'h44, 12);
        finish_vote(0, 0, 1, 0);

        send(8'hA5, 6);
        chk("settle_accept", int'(feat_out), 8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid   = 1;
            in_feature = 8'h5A ^ 8'(i);
            chk("settle_feat", int'(feat_out), 8'hA5);
            chk("settle_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        in_valid = 0;
        chk("sample_feat", int'(feat_out), 8'hA5);
        send(8'h52, 6); send(8'h53, 6); send(8'h54, 1);
        finish_vote(6, 3, 0, 0);

        send(8'h61, 0); send(8'h62, 8); send(8'h63, 8); send(8'h64, 8);
        finish_vote(8, 3, 0, 20);

        send(8'h71, 9); send(8'h72, 9);
        repeat (2) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_feat", int'(feat_out), 0);
        chk("mid_rst_class", int'(out_class), 0);
        chk("mid_rst_votes", int'(out_votes), 0);
        chk("mid_rst_err", int'(out_err), 0);
        @(negedge clk) rst = 0;
        send(8'h81, 9); send(8'h82, 9); send(8'h83, 9); send(8'h84, 9);
        finish_vote(9, 4, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
